rng_uart_streamer: RTL and testbench

Parametrised successor to the fixed 16-bit random-number UART path. It samples a WORD_WIDTH-bit random word at a programmable rate and buffers words in a FIFO. Each word is serialised as WORD_WIDTH/8 UART frames, least-significant byte first, with configurable parity and stop bits. It sits between the LFSR generator and the board UART pin, and reports overflow so that dropped samples are visible to the PC-side statistics.

---
 rtl/rng_uart_streamer.sv | 181 ++++++++++++++++++
 tb/tb_rng_uart_streamer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_uart_streamer.sv
// rng_uart_streamer: samples a random word at a fixed tick rate, buffers it
// in a small word FIFO and serialises each word as WORD_WIDTH/8 UART frames,
// least-significant byte first, with optional parity and 1 or 2 stop bits.
// Samples that arrive while the FIFO is full are dropped and counted.
module rng_uart_streamer #(
  parameter int WORD_WIDTH = 16,
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int SAMPLE_DIV = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WORD_WIDTH-1:0]         rand_word,
  input  logic                          rand_valid,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int BAUD_DIV  = CLK_FREQ / BAUD;
  localparam int NUM_BYTES = WORD_WIDTH / 8;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = PTR_W + 1;
  localparam int SCNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BCNT_W    = $clog2(BAUD_DIV);
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_next;
  logic [SCNT_W-1:0]       sample_cnt;
  logic                    tick;
  logic                    push_req, push, pop, full;
  logic [WORD_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [BCNT_W-1:0]       baud_cnt;
  logic                    bit_done;
  logic [2:0]              bit_cnt;
  logic [BYTE_W-1:0]       byte_idx;
  logic                    last_byte;
  logic [WORD_WIDTH-1:0]   shift_reg;

  assign tick      = (sample_cnt == SCNT_W'(SAMPLE_DIV - 1));
  assign push_req  = tick & en & rand_valid;
  assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign push      = push_req & ~full;
  assign bit_done  = (baud_cnt == BCNT_W'(BAUD_DIV - 1));
  assign last_byte = (byte_idx == BYTE_W'(NUM_BYTES - 1));
  assign busy      = (state != IDLE) || (fifo_level != '0);

  // Free-running sample-rate divider; it keeps counting whether or not sampling is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // Word storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rand_word;
    end
  end

  // FIFO pointers and level; a full FIFO refuses the push even when a pop frees a slot this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Dropped-sample bookkeeping: sticky flag plus a saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (push_req && full) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  // Transmit sequencing and the serial line value, decoded from the current state.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_done) begin
          state_next = DATA;
        end
      end
      DATA: begin
        tx = shift_reg[bit_cnt];
        if (bit_done && bit_cnt == 3'd7) begin
          state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx = (^shift_reg[7:0]) ^ ODD_BIT;
        if (bit_done) begin
          state_next = STOP;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (bit_done && bit_cnt == 3'(STOP_BITS - 1)) begin
          state_next = last_byte ? IDLE : START;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus bit timing; counters restart whenever a new state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == IDLE || bit_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (bit_done) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        byte_idx  <= '0;
      end else if (state == STOP && state_next == START) begin
        shift_reg <= shift_reg >> 8;
        byte_idx  <= byte_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rng_uart_streamer.sv
// Testbench for rng_uart_streamer: three differently parameterised instances
// checked every cycle against a word-level timing model, plus table-driven
// frame vectors and directed overflow / reset sequences.
module tb_rng_uart_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en_v, rv_v;
  logic [63:0] word_v [3];

  logic        tx0, tx1, tx2, busy0, busy1, busy2, ov0, ov1, ov2;
  logic [2:0]  lvl0;
  logic [1:0]  lvl1, lvl2;
  logic [15:0] drop0, drop1, drop2;

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;

  // Word-level reference model state per instance.
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [63:0] q2 [$];
  int          m_now [3];
  int          m_idle_at [3];
  int          m_start [3];
  logic        m_over [3];
  int          m_drop [3];
  logic [63:0] m_word [3];

  typedef struct {
    int          inst;
    logic [63:0] word;
    string       bits;
  } vec_t;

  vec_t tbl [5];

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  rng_uart_streamer #(.WORD_WIDTH(16), .CLK_FREQ(16), .BAUD(1), .SAMPLE_DIV(1),
                      .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .rand_word(word_v[0][15:0]), .rand_valid(rv_v[0]),
    .tx(tx0), .busy(busy0), .fifo_level(lvl0), .overflow(ov0), .drop_count(drop0));

  rng_uart_streamer #(.WORD_WIDTH(32), .CLK_FREQ(8), .BAUD(2), .SAMPLE_DIV(5),
                      .FIFO_DEPTH(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .rand_word(word_v[1][31:0]), .rand_valid(rv_v[1]),
    .tx(tx1), .busy(busy1), .fifo_level(lvl1), .overflow(ov1), .drop_count(drop1));

  rng_uart_streamer #(.WORD_WIDTH(8), .CLK_FREQ(4), .BAUD(2), .SAMPLE_DIV(3),
                      .FIFO_DEPTH(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .rand_word(word_v[2][7:0]), .rand_valid(rv_v[2]),
    .tx(tx2), .busy(busy2), .fifo_level(lvl2), .overflow(ov2), .drop_count(drop2));

  function automatic int p_bd(int k);  return (k == 0) ? 16 : (k == 1) ? 4 : 2;  endfunction
  function automatic int p_sd(int k);  return (k == 0) ? 1 : (k == 1) ? 5 : 3;   endfunction
  function automatic int p_dep(int k); return (k == 0) ? 4 : 2;                  endfunction
  function automatic int p_ww(int k);  return (k == 0) ? 16 : (k == 1) ? 32 : 8; endfunction
  function automatic int p_pe(int k);  return (k == 2) ? 0 : 1;                  endfunction
  function automatic int p_po(int k);  return (k == 1) ? 1 : 0;                  endfunction
  function automatic int p_sb(int k);  return (k == 1) ? 2 : 1;                  endfunction
  function automatic int p_nb(int k);  return p_ww(k) / 8;                       endfunction
  function automatic int p_fl(int k);  return 1 + 8 + p_pe(k) + p_sb(k);         endfunction

  function automatic logic d_tx(int k);
    return (k == 0) ? tx0 : (k == 1) ? tx1 : tx2;
  endfunction
  function automatic logic d_busy(int k);
    return (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
  endfunction
  function automatic logic d_ov(int k);
    return (k == 0) ? ov0 : (k == 1) ? ov1 : ov2;
  endfunction
  function automatic int d_lvl(int k);
    return (k == 0) ? int'(lvl0) : (k == 1) ? int'(lvl1) : int'(lvl2);
  endfunction
  function automatic int d_drop(int k);
    return (k == 0) ? int'(drop0) : (k == 1) ? int'(drop1) : int'(drop2);
  endfunction

  function automatic int q_size(int k);
    return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
  endfunction

  task automatic q_clear(int k);
    if (k == 0) q0.delete(); else if (k == 1) q1.delete(); else q2.delete();
  endtask

  task automatic q_push(int k, logic [63:0] w);
    if (k == 0) q0.push_back(w); else if (k == 1) q1.push_back(w); else q2.push_back(w);
  endtask

  task automatic q_pop(int k, output logic [63:0] w);
    if (k == 0) w = q0.pop_front(); else if (k == 1) w = q1.pop_front(); else w = q2.pop_front();
  endtask

  task automatic check(string name, int k, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s u%0d cycle %0d: got %0d, expected %0d", name, k, gcyc, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were present during that cycle.
  task automatic model_step(int k, logic r, logic e, logic v, logic [63:0] w);
    logic        tick, preq, full, idle;
    logic [63:0] popped;
    logic [63:0] mask;
    if (r) begin
      q_clear(k);
      m_now[k]     = 0;
      m_idle_at[k] = 0;
      m_start[k]   = 0;
      m_over[k]    = 1'b0;
      m_drop[k]    = 0;
      return;
    end
    mask = (64'd1 << p_ww(k)) - 64'd1;
    idle = (m_now[k] >= m_idle_at[k]);
    tick = ((m_now[k] % p_sd(k)) == p_sd(k) - 1);
    preq = tick && e && v;
    full = (q_size(k) == p_dep(k));
    if (preq && full) begin
      m_over[k] = 1'b1;
      if (m_drop[k] < 65535) m_drop[k]++;
    end
    if (idle && q_size(k) > 0) begin
      q_pop(k, popped);
      m_word[k]    = popped;
      m_start[k]   = m_now[k] + 1;
      m_idle_at[k] = m_now[k] + 1 + p_nb(k) * p_fl(k) * p_bd(k);
    end
    if (preq && !full) q_push(k, w & mask);
    m_now[k]++;
  endtask

  // Expected line level: locate the current bit by elapsed time since the word's start bit.
  function automatic logic m_tx(int k);
    int         off, bitn, fr, pos;
    logic [7:0] b;
    if (m_now[k] >= m_idle_at[k]) return 1'b1;
    off  = m_now[k] - m_start[k];
    bitn = off / p_bd(k);
    fr   = bitn / p_fl(k);
    pos  = bitn % p_fl(k);
    b    = 8'(m_word[k] >> (8 * fr));
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (p_pe(k) != 0 && pos == 9) return (^b) ^ (p_po(k) != 0);
    return 1'b1;
  endfunction

  task automatic checkOutput(int k);
    check("tx", k, d_tx(k), m_tx(k));
    check("busy", k, d_busy(k), (m_now[k] < m_idle_at[k]) || (q_size(k) != 0));
    check("fifo_level", k, d_lvl(k), q_size(k));
    check("overflow", k, d_ov(k), m_over[k]);
    check("drop_count", k, d_drop(k), m_drop[k]);
  endtask

  task automatic applyStimulus();
    logic        prst;
    logic [2:0]  pen, prv;
    logic [63:0] pw [3];
    prst = rst;
    pen  = en_v;
    prv  = rv_v;
    pw   = word_v;
    @(posedge clk);
    #1;
    gcyc++;
    for (int k = 0; k < 3; k++) model_step(k, prst, pen[k], prv[k], pw[k]);
    for (int k = 0; k < 3; k++) checkOutput(k);
  endtask

  task automatic run_vector(vec_t v);
    int k, bd, n, t_push, fall, target;
    k  = v.inst;
    bd = p_bd(k);
    n  = 0;
    while (d_busy(k) && n < 5000) begin applyStimulus(); n++; end
    check("idle_wait", k, d_busy(k), 0);
    n = 0;
    while ((m_now[k] % p_sd(k)) != p_sd(k) - 1 && n < 100) begin applyStimulus(); n++; end
    en_v[k]   = 1'b1;
    word_v[k] = v.word;
    rv_v[k]   = 1'b1;
    t_push    = gcyc;
    applyStimulus();
    rv_v[k] = 1'b0;
    n = 0;
    while (d_tx(k) != 1'b0 && n < 100) begin applyStimulus(); n++; end
    check("tx_fall_latency", k, gcyc - t_push, 2);
    fall = gcyc;
    for (int i = 0; i < v.bits.len(); i++) begin
      target = fall + i * bd + bd / 2;
      while (gcyc < target) applyStimulus();
      check("frame_bit", k, d_tx(k), (v.bits[i] == "1"));
    end
    n = 0;
    while (d_busy(k) && n < 2000) begin applyStimulus(); n++; end
    check("busy_end", k, gcyc - fall, v.bits.len() * bd);
  endtask

  initial begin
    int max_lvl, low_cnt, fall, n;

    for (int k = 0; k < 3; k++) begin
      m_now[k] = 0; m_idle_at[k] = 0; m_start[k] = 0;
      m_over[k] = 1'b0; m_drop[k] = 0; m_word[k] = '0;
      word_v[k] = '0;
    end
    rst  = 1'b1;
    en_v = '0;
    rv_v = '0;

    tbl[0] = '{0, 64'hA55A,     {"00101101001", "01010010101"}};
    tbl[1] = '{0, 64'h0001,     {"01000000011", "00000000001"}};
    tbl[2] = '{1, 64'h00000001, {"010000000011", "000000000111", "000000000111", "000000000111"}};
    tbl[3] = '{1, 64'h11223344, {"000100010111", "011001100111", "001000100111", "010001000111"}};
    tbl[4] = '{2, 64'h96,       "0011010011"};

    $display("[TB] reset and idle");
    repeat (3) applyStimulus();
    rst = 1'b0;
    repeat (1000) applyStimulus();
    check("idle_tx", 0, tx0, 1);
    check("idle_busy", 0, busy0, 0);
    check("idle_level", 0, lvl0, 0);
    check("idle_drop", 0, drop0, 0);

    $display("[TB] frame vectors");
    for (int i = 0; i < 5; i++) run_vector(tbl[i]);

    $display("[TB] overflow");
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    en_v[0] = 1'b1;
    rv_v[0] = 1'b1;
    max_lvl = 0;
    for (int i = 0; i < 20; i++) begin
      word_v[0] = 64'(16'h0100 + i);
      applyStimulus();
      if (int'(lvl0) > max_lvl) max_lvl = int'(lvl0);
    end
    rv_v[0] = 1'b0;
    check("ovf_max_level", 0, max_lvl, 4);
    check("ovf_flag", 0, ov0, 1);
    check("ovf_drops", 0, drop0, 15);
    n = 0;
    while (busy0 && n < 3000) begin applyStimulus(); n++; end
    check("ovf_drain", 0, busy0, 0);
    check("ovf_drops_kept", 0, drop0, 15);

    $display("[TB] reset mid-frame");
    rv_v[0] = 1'b1;
    word_v[0] = 64'h5A5A;
    applyStimulus();
    word_v[0] = 64'h1234;
    applyStimulus();
    rv_v[0] = 1'b0;
    n = 0;
    while (tx0 != 1'b0 && n < 100) begin applyStimulus(); n++; end
    fall = gcyc;
    while (gcyc < fall + 4 * 16 + 8) applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    check("rst_tx", 0, tx0, 1);
    check("rst_level", 0, lvl0, 0);
    check("rst_drop", 0, drop0, 0);
    check("rst_overflow", 0, ov0, 0);
    low_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      if (tx0 == 1'b0) low_cnt++;
    end
    check("rst_no_residual", 0, low_cnt, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 12000; i++) begin
      for (int k = 0; k < 3; k++) begin
        en_v[k]   = ($urandom_range(0, 9) != 0);
        word_v[k] = {$urandom, $urandom};
      end
      rv_v[0] = ($urandom_range(0, 199) == 0);
      rv_v[1] = ($urandom_range(0, 29) == 0);
      rv_v[2] = ($urandom_range(0, 5) == 0);
      rst     = ($urandom_range(0, 3999) == 0);
      applyStimulus();
    end
    rst  = 1'b0;
    rv_v = '0;
    repeat (5) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
